// File: rtl/ysyx_23060061_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter.
// State and owner encodings plus default bus widths.
package ysyx_23060061_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_23060061_rr_arb2.sv
// Two-way round-robin grant, combinational.
// Grant bit 0 is IFU, bit 1 is LSU.
module ysyx_23060061_rr_arb2
  import ysyx_23060061_mem_arbiter_pkg::*;
(
  input  logic       i_v_ifu,
  input  logic       i_v_lsu,
  input  owner_e     i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    unique case (1'b1)
      (i_v_ifu && i_v_lsu):
        o_grant = (i_last == OWN_LSU) ? 2'b01 : 2'b10;
      (i_v_ifu && !i_v_lsu):
        o_grant = 2'b01;
      (!i_v_ifu && i_v_lsu):
        o_grant = 2'b10;
      default:
        o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Single-outstanding IFU/LSU arbiter onto one memory port.
// IDLE grants, REQ presents the latched request, RESP routes back.
module ysyx_23060061_mem_arbiter
  import ysyx_23060061_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_resp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp_err
);

  state_e            r_state;
  state_e            w_state_nxt;
  owner_e            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wmask;
  logic [1:0]        w_grant;
  logic              w_take;
  logic              w_in_resp;
  logic              w_own_rdy;

  ysyx_23060061_rr_arb2 u_arb (
    .i_v_ifu (ifu_req_valid),
    .i_v_lsu (lsu_req_valid),
    .i_last  (r_owner),
    .o_grant (w_grant)
  );

  // r_owner doubles as last_owner for the round-robin tie-break
  assign w_take    = rst && (r_state == IDLE) && (|w_grant);
  assign w_in_resp = (r_state == RESP);
  assign w_own_rdy = (r_owner == OWN_LSU) ? lsu_resp_ready
                                          : ifu_resp_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_take) w_state_nxt = REQ;
      REQ:     if (mem_req_ready) w_state_nxt = RESP;
      RESP:    if (mem_resp_valid && w_own_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= OWN_LSU;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_owner <= w_grant[1] ? OWN_LSU : OWN_IFU;
        r_addr  <= w_grant[1] ? lsu_addr : ifu_addr;
        r_wen   <= w_grant[1] && lsu_wen;
        r_wdata <= w_grant[1] ? lsu_wdata : '0;
        r_wmask <= w_grant[1] ? lsu_wmask : 4'b0000;
      end
    end
  end

  always_comb begin
    ifu_req_ready  = w_take && w_grant[0];
    lsu_req_ready  = w_take && w_grant[1];
    mem_req_valid  = (r_state == REQ);
    mem_addr       = r_addr;
    mem_wen        = r_wen;
    mem_wdata      = r_wdata;
    mem_wmask      = r_wmask;
    mem_resp_ready = w_in_resp && w_own_rdy;
    ifu_resp_valid = w_in_resp && (r_owner == OWN_IFU) && mem_resp_valid;
    lsu_resp_valid = w_in_resp && (r_owner == OWN_LSU) && mem_resp_valid;
    ifu_resp_err   = w_in_resp && (r_owner == OWN_IFU) && mem_resp_err;
    lsu_resp_err   = w_in_resp && (r_owner == OWN_LSU) && mem_resp_err;
    ifu_rdata      = mem_rdata;
    lsu_rdata      = mem_rdata;
  end

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter.
// Random masters and memory, with a transaction-level reference model.
module tb_ysyx_23060061_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  ysyx_23060061_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mreq_t;

  typedef struct packed {
    bit          own;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  int    n_chk  = 0;
  int    n_fail = 0;
  int    n_done = 0;
  bit    fast   = 1;
  bit    running;
  mreq_t mq[$];
  resp_t rq[$];
  bit    m_busy, m_last;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5EAD_BEEF;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[4] & a[2];
  endfunction

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory: answers f(addr) after a random delay, junk when idle
  initial begin
    bit          ph;
    bit          hs_q, hs_r;
    int          dly;
    logic [31:0] a_s, m_a;
    ph = 0; dly = 0; m_a = '0;
    mem_req_ready = 0; mem_resp_valid = 0;
    mem_rdata = '0; mem_resp_err = 0;
    forever begin
      @(negedge clk);
      hs_q = mem_req_valid && mem_req_ready;
      hs_r = mem_resp_valid && mem_resp_ready;
      a_s  = mem_addr;
      @(posedge clk); #1;
      if (!rst) begin
        ph = 0; mem_req_ready = 0; mem_resp_valid = 0;
      end else begin
        if (ph && hs_r) ph = 0;
        if (!ph && hs_q) begin
          ph = 1; m_a = a_s;
          dly = fast ? 0 : int'($urandom_range(0, 3));
        end
        if (ph) begin
          mem_req_ready = 0;
          if (dly == 0) begin
            mem_resp_valid = 1;
            mem_rdata = mem_f(m_a);
            mem_resp_err = mem_err(m_a);
          end else begin
            dly--;
            mem_resp_valid = 0;
            mem_rdata = $urandom;
          end
        end else begin
          mem_req_ready = fast || ($urandom_range(0, 2) != 0);
          mem_resp_valid = !fast && !mem_req_ready &&
                           ($urandom_range(0, 3) == 0);
          mem_rdata = $urandom;
          mem_resp_err = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // scoreboard monitor with a transaction-level arbiter model
  bit e_gi, e_gl, e_mreq, e_inresp, e_rv, ow_rdy;
  mreq_t nm_req;
  resp_t nm_rsp, d_rsp;
  mreq_t d_req;

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outs", {ifu_req_ready, lsu_req_ready, ifu_resp_valid,
                         lsu_resp_valid, mem_req_valid, mem_resp_ready}, 0);
      m_busy = 0; m_last = 1;
      mq.delete(); rq.delete();
    end else begin
      e_gi = !m_busy && ifu_req_valid && (!lsu_req_valid || m_last);
      e_gl = !m_busy && lsu_req_valid && !e_gi;
      chk("req_ready", {ifu_req_ready, lsu_req_ready}, {e_gi, e_gl});
      e_mreq = m_busy && (mq.size() != 0);
      chk("mem_req_valid", mem_req_valid, e_mreq);
      if (e_mreq)
        chk("mem_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, mq[0]);
      e_inresp = m_busy && (mq.size() == 0) && (rq.size() != 0);
      ow_rdy = 0;
      if (e_inresp) ow_rdy = rq[0].own ? lsu_resp_ready : ifu_resp_ready;
      e_rv = e_inresp && mem_resp_valid;
      chk("resp_valid", {ifu_resp_valid, lsu_resp_valid},
          {e_rv && !rq[0].own, e_rv && rq[0].own});
      chk("mem_resp_ready", mem_resp_ready, e_inresp && ow_rdy);
      chk("rdata_pass", {ifu_rdata, lsu_rdata}, {mem_rdata, mem_rdata});
      if (e_rv) begin
        if (rq[0].own)
          chk("lsu_resp", {lsu_rdata, lsu_resp_err},
              {rq[0].rdata, rq[0].err});
        else
          chk("ifu_resp", {ifu_rdata, ifu_resp_err},
              {rq[0].rdata, rq[0].err});
      end
      if (e_rv && ow_rdy) begin
        d_rsp = rq.pop_front();
        m_busy = 0;
        n_done++;
      end else if (e_mreq && mem_req_ready) begin
        d_req = mq.pop_front();
      end
      if (e_gi || e_gl) begin
        if (e_gi) nm_req = '{ifu_addr, 1'b0, 32'h0, 4'h0};
        else      nm_req = '{lsu_addr, lsu_wen, lsu_wdata, lsu_wmask};
        nm_rsp = '{e_gl, mem_f(nm_req.addr), mem_err(nm_req.addr)};
        mq.push_back(nm_req);
        rq.push_back(nm_rsp);
        m_busy = 1;
        m_last = e_gl;
      end
    end
  end

  task automatic run_ifu(input int n, input int gmax);
    int k;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
      ifu_req_valid = 1;
      ifu_addr = {$urandom} & 32'hFFFF_FFFC;
      k = 0;
      do begin @(negedge clk); k++; end
      while (!ifu_req_ready && k < 400);
      if (k >= 400) chk("ifu_req_timeout", ifu_req_ready, 1);
      @(posedge clk); #1;
      ifu_req_valid = 0;
    end
  endtask

  task automatic run_lsu(input int n, input int gmax);
    int k;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
      lsu_req_valid = 1;
      lsu_addr  = {$urandom} & 32'hFFFF_FFFC;
      lsu_wen   = 1'($urandom_range(0, 1));
      lsu_wdata = $urandom;
      lsu_wmask = 4'($urandom_range(0, 15));
      k = 0;
      do begin @(negedge clk); k++; end
      while (!lsu_req_ready && k < 400);
      if (k >= 400) chk("lsu_req_timeout", lsu_req_ready, 1);
      @(posedge clk); #1;
      lsu_req_valid = 0;
    end
  endtask

  task automatic random_phase(input int n, input int gmax);
    running = 1;
    fork
      begin
        fork
          run_ifu(n, gmax);
          run_lsu(n, gmax);
        join
        running = 0;
      end
      begin
        while (running) begin
          @(posedge clk); #1;
          ifu_resp_ready = ($urandom_range(0, 2) != 0);
          lsu_resp_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
  endtask

  initial begin
    int k;
    rst = 0;
    ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0;
    lsu_wdata = '0; lsu_wmask = '0; lsu_resp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; ifu_resp_ready = 1;
    lsu_resp_ready = 1;
    @(negedge clk);
    chk("first_grant", {ifu_req_ready, lsu_req_ready}, 2'b10);
    @(posedge clk); #1;
    ifu_req_valid = 0;
    @(negedge clk);
    chk("lat_mem_req", {mem_req_valid, mem_addr}, {1'b1, 32'h8000_0000});
    @(negedge clk);
    chk("lat_resp", {ifu_resp_valid, ifu_rdata, ifu_resp_err},
        {1'b1, 32'hDEAD_BEEF, 1'b0});
    @(posedge clk); #1;

    ifu_resp_ready = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    @(posedge clk); #1;
    ifu_req_valid = 0;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!ifu_resp_valid && k < 20);
    chk("pre_reset_resp", ifu_resp_valid, 1);
    #2;
    rst = 0;
    #1;
    chk("async_reset", {ifu_req_ready, lsu_req_ready, ifu_resp_valid,
                        lsu_resp_valid, mem_req_valid, mem_resp_ready}, 0);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0080;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 4'b0011;
    ifu_resp_ready = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("regrant_ifu", {ifu_req_ready, lsu_req_ready}, 2'b10);
    @(posedge clk); #1;
    ifu_req_valid = 0;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!lsu_req_ready && k < 40);
    chk("lsu_after_ifu", lsu_req_ready, 1);
    @(posedge clk); #1;
    lsu_req_valid = 0;

    fast = 0;
    random_phase(60, 3);
    random_phase(30, 0);

    ifu_resp_ready = 1; lsu_resp_ready = 1;
    k = 0;
    while (m_busy && k < 200) begin @(negedge clk); k++; end
    chk("drain", m_busy, 0);
    chk("completions_min", n_done >= 150, 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
